// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
//   Handshake bundle between the EX stage and the MUL/CLO/CLZ sequencer.
//   Pipeline side (master) drives the EX instruction description; the
//   sequencer (slave) returns stall, start and write-enable strobes.
// Signals
//   IssueValid  valid, unflushed instruction in EX
//   MULOp       EX instruction targets the multiply unit
//   Func[5:0]   EX function field
//   HiLoRead    EX instruction is MFHI/MFLO
//   Flush       kill the EX instruction this cycle
//   Stall       hold IF/ID/EX (combinational)
//   MulStart    unit latches operands and Func (combinational pulse)
//   ActFunc     registered Func of the in-flight op
//   MulBusy     an op is in flight
//   MulWbEn     write unit result to the GPR (pulse)
//   HiLoWbEn    write unit result to HI/LO (pulse)
interface mul_seq_ctrl_if;
  logic       IssueValid;
  logic       MULOp;
  logic [5:0] Func;
  logic       HiLoRead;
  logic       Flush;
  logic       Stall;
  logic       MulStart;
  logic [5:0] ActFunc;
  logic       MulBusy;
  logic       MulWbEn;
  logic       HiLoWbEn;

  modport master (
    output IssueValid, MULOp, Func, HiLoRead, Flush,
    input  Stall, MulStart, ActFunc, MulBusy, MulWbEn, HiLoWbEn
  );

  modport slave (
    input  IssueValid, MULOp, Func, HiLoRead, Flush,
    output Stall, MulStart, ActFunc, MulBusy, MulWbEn, HiLoWbEn
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Latency-counted sequencer for the multi-cycle MUL/CLO/CLZ unit in EX.
//   GPR-result ops (MUL, CLO, CLZ) freeze the pipeline until their result is
//   written. HI/LO ops (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) run in the
//   background and only stall a later multiply-unit op or an MFHI/MFLO.
// Ports
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset
//   bus   mul_seq_ctrl_if.slave (EX instruction in, stall/start/wb strobes out)
// Parameters
//   MUL_LAT  issue-to-result cycles for MUL and all HI/LO ops (1..2**CNT_W)
//   CNT_LAT  issue-to-result cycles for CLO/CLZ (1..2**CNT_W)
//   CNT_W    latency counter width
module mul_seq_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_LAT = 2,
  parameter int CNT_W   = 4
) (
  input logic           clk,
  input logic           nrst,
  mul_seq_ctrl_if.slave bus
);

  // Function codes shared with the decoder (SPECIAL / SPECIAL2 space,
  // disambiguated by MULOp).
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_CLZ   = 6'h20;
  localparam logic [5:0] F_CLO   = 6'h21;

  // The counter is loaded with Lat-1 so the done cycle lands Lat cycles after issue.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_CNT = CNT_W'(CNT_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN_G,
    RUN_H
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       act_func, act_func_nxt;
  logic             is_cnt, is_g, is_h, done;
  logic             issue_ok, issue;
  logic             stall, start, wb, hwb;
  logic [CNT_W-1:0] lat_cnt;

  // Classify the EX instruction; anything outside G/H is invisible to the unit.
  always_comb begin
    is_cnt  = (bus.Func == F_CLO) || (bus.Func == F_CLZ);
    is_g    = bus.MULOp && (is_cnt || (bus.Func == F_MUL));
    is_h    = bus.MULOp && ((bus.Func == F_MULT) || (bus.Func == F_MULTU) ||
                            (bus.Func == F_MADD) || (bus.Func == F_MADDU) ||
                            (bus.Func == F_MSUB) || (bus.Func == F_MSUBU));
    lat_cnt = is_cnt ? CNT_CNT : MUL_CNT;
    done    = (state != IDLE) && (cnt == '0);
  end

  // Next-state and strobe logic. The per-state case decides whether an issue
  // may be accepted and what the in-flight op contributes to Stall; a common
  // issue block then overlays the start actions. Issue is gated by nrst so
  // that all outputs fall as soon as reset asserts, regardless of inputs.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_func_nxt = act_func;
    stall        = 1'b0;
    start        = 1'b0;
    wb           = 1'b0;
    hwb          = 1'b0;
    issue_ok     = 1'b0;
    issue        = 1'b0;

    case (state)
      IDLE: begin
        issue_ok = 1'b1;
      end
      RUN_G: begin
        // A flush kills the instruction waiting on the result, so the op is
        // dropped without a write-back even in its done cycle.
        if (bus.Flush) begin
          state_nxt = IDLE;
        end else if (done) begin
          wb        = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt - 1'b1;
        end
      end
      RUN_H: begin
        if (done) begin
          hwb       = 1'b1;
          state_nxt = IDLE;
          issue_ok  = 1'b1;
          stall     = bus.IssueValid && bus.HiLoRead;
        end else begin
          stall   = bus.IssueValid && (is_g || is_h || bus.HiLoRead);
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    issue = nrst && issue_ok && bus.IssueValid && (is_g || is_h) && !bus.Flush;
    if (issue) begin
      start        = 1'b1;
      act_func_nxt = bus.Func;
      cnt_nxt      = lat_cnt;
      state_nxt    = is_g ? RUN_G : RUN_H;
      if (is_g) begin
        stall = 1'b1;
      end
    end
  end

  // State, latency counter and active-function registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      act_func <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      act_func <= act_func_nxt;
    end
  end

  assign bus.Stall    = stall;
  assign bus.MulStart = start;
  assign bus.ActFunc  = act_func;
  assign bus.MulBusy  = (state != IDLE);
  assign bus.MulWbEn  = wb;
  assign bus.HiLoWbEn = hwb;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
//   Scoreboard bench for mul_seq_ctrl. The driver applies one EX instruction
//   per cycle, asks a deadline-based reference model what the sequencer must
//   show in that cycle and queues it; a monitor on the falling edge pops and
//   compares. Directed sequences cover the documented scenarios, followed by
//   random traffic and a mid-op asynchronous reset.
module tb_mul_seq_ctrl;
  localparam int MUL_LAT = 4;
  localparam int CNT_LAT = 2;
  localparam int CNT_W   = 4;

  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_CLZ   = 6'h20;
  localparam logic [5:0] F_CLO   = 6'h21;
  localparam logic [5:0] F_ALU   = 6'h20;

  typedef struct packed {
    logic       stall;
    logic       start;
    logic       wb;
    logic       hwb;
    logic       busy;
    logic [5:0] func;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  mul_seq_ctrl_if bus();

  mul_seq_ctrl #(.MUL_LAT(MUL_LAT), .CNT_LAT(CNT_LAT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   popped = 0;

  // Reference model: an in-flight op is described by its class and the
  // absolute cycle at which its result is due.
  bit         m_active;
  bit         m_isg;
  int         m_done_at;
  logic [5:0] m_func;
  int         cyc = 0;

  function automatic bit isG(input logic mulop, input logic [5:0] f);
    return mulop && (f == F_MUL || f == F_CLO || f == F_CLZ);
  endfunction

  function automatic bit isH(input logic mulop, input logic [5:0] f);
    return mulop && (f == F_MULT || f == F_MULTU || f == F_MADD ||
                     f == F_MADDU || f == F_MSUB || f == F_MSUBU);
  endfunction

  function automatic int latOf(input logic [5:0] f);
    return (f == F_CLO || f == F_CLZ) ? CNT_LAT : MUL_LAT;
  endfunction

  task automatic modelReset();
    m_active = 1'b0;
    m_isg    = 1'b0;
    m_func   = 6'h00;
  endtask

  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic driveInputs(input logic iv, input logic mulop, input logic [5:0] f,
                             input logic hilo, input logic flush);
    bus.IssueValid = iv;
    bus.MULOp      = mulop;
    bus.Func       = f;
    bus.HiLoRead   = hilo;
    bus.Flush      = flush;
  endtask

  // One EX cycle: drive after the edge, predict and queue the expected outputs.
  task automatic applyStimulus(input logic iv, input logic mulop, input logic [5:0] f,
                               input logic hilo, input logic flush);
    exp_t e;
    bit   g, want, done, can, issue;
    @(posedge clk);
    #1;
    driveInputs(iv, mulop, f, hilo, flush);
    g     = isG(mulop, f);
    want  = iv && (g || isH(mulop, f));
    done  = m_active && (cyc == m_done_at);
    can   = !m_active || (!m_isg && done);
    issue = want && !flush && can;
    e.busy  = m_active;
    e.func  = m_func;
    e.start = issue;
    e.wb    = m_active && m_isg && done && !flush;
    e.hwb   = m_active && !m_isg && done;
    if (m_active && m_isg)
      e.stall = !done && !flush;
    else if (m_active)
      e.stall = done ? ((iv && hilo) || (issue && g)) : (want || (iv && hilo));
    else
      e.stall = issue && g;
    expq.push_back(e);
    if (issue) begin
      m_active  = 1'b1;
      m_isg     = g;
      m_done_at = cyc + latOf(f);
      m_func    = f;
    end else if (done || (m_active && m_isg && flush)) begin
      m_active = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic hold(input logic [5:0] f, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, f, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    string tag;
    tag = $sformatf("c%0d", popped);
    cmp({"Stall ", tag},    {5'b0, bus.Stall},    {5'b0, e.stall});
    cmp({"MulStart ", tag}, {5'b0, bus.MulStart}, {5'b0, e.start});
    cmp({"MulWbEn ", tag},  {5'b0, bus.MulWbEn},  {5'b0, e.wb});
    cmp({"HiLoWbEn ", tag}, {5'b0, bus.HiLoWbEn}, {5'b0, e.hwb});
    cmp({"MulBusy ", tag},  {5'b0, bus.MulBusy},  {5'b0, e.busy});
    cmp({"ActFunc ", tag},  bus.ActFunc,          e.func);
    popped++;
  endtask

  // Outputs are all-zero whenever reset is asserted.
  task automatic checkResetOutputs(input string name);
    cmp({name, " Stall"},    {5'b0, bus.Stall},    6'h00);
    cmp({name, " MulStart"}, {5'b0, bus.MulStart}, 6'h00);
    cmp({name, " MulBusy"},  {5'b0, bus.MulBusy},  6'h00);
    cmp({name, " MulWbEn"},  {5'b0, bus.MulWbEn},  6'h00);
    cmp({name, " HiLoWbEn"}, {5'b0, bus.HiLoWbEn}, 6'h00);
    cmp({name, " ActFunc"},  bus.ActFunc,          6'h00);
  endtask

  // Monitor: compare whenever a prediction is pending for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  logic [5:0] rfuncs [12];

  initial begin
    rfuncs = '{F_MUL, F_CLO, F_CLZ, F_MULT, F_MULTU, F_MADD,
               F_MADDU, F_MSUB, F_MSUBU, 6'h03, 6'h10, 6'h3F};
    modelReset();
    nrst = 1'b0;
    // Issue-looking inputs while in reset must not leak to the outputs.
    driveInputs(1'b1, 1'b1, F_MUL, 1'b0, 1'b0);
    #3;
    checkResetOutputs("reset-pre-edge");
    @(posedge clk);
    @(posedge clk);
    #2;
    checkResetOutputs("reset-after-edges");
    driveInputs(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    nrst = 1'b1;
    idle(2);

    // MUL: stall through c3, write-back at c4.
    hold(F_MUL, 5);
    idle(2);
    // CLZ: short latency.
    hold(F_CLZ, 3);
    idle(2);
    // MULT followed by unrelated ALU ops: no stall.
    applyStimulus(1'b1, 1'b1, F_MULT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, F_ALU, 1'b0, 1'b0);
    idle(2);
    // MULT then MFLO at c2: waits past the HI/LO write.
    applyStimulus(1'b1, 1'b1, F_MULT, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, F_ALU, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 6'h12, 1'b1, 1'b0);
    idle(2);
    // MULT then MADD back-to-back.
    applyStimulus(1'b1, 1'b1, F_MULT, 1'b0, 1'b0);
    hold(F_MADD, 4);
    idle(5);
    // MUL flushed at c2.
    hold(F_MUL, 2);
    applyStimulus(1'b1, 1'b1, F_MUL, 1'b0, 1'b1);
    idle(3);
    // MULT with an unrelated flush at c2 still completes.
    applyStimulus(1'b1, 1'b1, F_MULTU, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, F_ALU, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, F_ALU, 1'b0, 1'b1);
    idle(3);

    // Mid-op asynchronous reset at c2 of a MUL.
    hold(F_MUL, 2);
    @(posedge clk);
    #2;
    cmp("pre-reset MulBusy", {5'b0, bus.MulBusy}, 6'h01);
    nrst = 1'b0;
    #1;
    checkResetOutputs("async-reset");
    modelReset();
    @(posedge clk);
    #1;
    driveInputs(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    nrst = 1'b1;
    idle(2);
    hold(F_MUL, 5);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic iv, mulop, hilo, flush;
      iv    = ($urandom_range(0, 3) != 0);
      mulop = ($urandom_range(0, 3) != 0);
      hilo  = iv && !mulop && ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      applyStimulus(iv, mulop, rfuncs[$urandom_range(0, 11)], hilo, flush);
    end
    idle(1);
    @(negedge clk);
    #1;
    cmp("scoreboard drained", 6'(expq.size()), 6'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
